// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches one instruction, waits for execute, then
// updates the PC from the resolved branch/jump target. Misaligned targets trap.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        branch,
  input  logic        jump,
  input  logic        jalr,
  input  logic        zero,
  input  logic        lt,
  input  logic        ltu,
  input  logic [31:0] imm,
  input  logic [31:0] alu_result,
  input  logic        ex_done,
  input  logic        halt,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret,
  output logic        misalign_trap,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StExec   = 3'd2,
    StUpdate = 3'd3,
    StTrap   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instret_q, instret_d;
  logic        trap_q, trap_d;
  logic [31:0] next_pc_q, next_pc_d;

  logic        cond_met;
  logic        taken;
  logic [31:0] target;

  // jalr targets always clear bit 0, so the ALU lsb is never consumed.
  logic unused_alu_lsb;
  assign unused_alu_lsb = alu_result[0];

  always_comb begin
    cond_met = 1'b0;
    case (instr_q[14:12])
      3'b000:  cond_met = zero;
      3'b001:  cond_met = ~zero;
      3'b100:  cond_met = lt;
      3'b101:  cond_met = ~lt;
      3'b110:  cond_met = ltu;
      3'b111:  cond_met = ~ltu;
      default: cond_met = 1'b0;
    endcase
  end

  assign taken = jump | (branch & cond_met);

  always_comb begin
    if (jump && jalr) begin
      target = {alu_result[31:1], 1'b0};
    end else if (taken) begin
      target = pc_q + imm;
    end else begin
      target = pc_q + 32'd4;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    instret_d     = instret_q;
    trap_d        = trap_q;
    next_pc_d     = next_pc_q;

    case (state_q)
      StIdle: begin
        if (!halt) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (imem_ready) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = StExec;
        end
      end
      StExec: begin
        if (ex_done) begin
          next_pc_d = target;
          if (target[1:0] != 2'b00) begin
            trap_d  = 1'b1;
            state_d = StTrap;
          end else begin
            state_d = StUpdate;
          end
        end
      end
      StUpdate: begin
        pc_d      = next_pc_q;
        instret_d = instret_q + 32'd1;
        state_d   = halt ? StIdle : StFetch;
      end
      StTrap: begin
        // Sticky until reset; PC and retire count stay frozen.
        trap_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0;
      instr_valid_q <= 1'b0;
      instret_q     <= 32'h0;
      trap_q        <= 1'b0;
      next_pc_q     <= RESET_PC;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      instret_q     <= instret_d;
      trap_q        <= trap_d;
      next_pc_q     <= next_pc_d;
    end
  end

  assign imem_req      = (state_q == StFetch);
  assign imem_addr     = pc_q;
  assign instr         = instr_q;
  assign instr_valid   = instr_valid_q;
  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign instret       = instret_q;
  assign misalign_trap = trap_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed corner cases plus a randomized
// instruction stream checked against an architectural next-PC model.
module tb_pc_sequencer;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        branch, jump, jalr;
  logic        zero, lt, ltu;
  logic [31:0] imm, alu_result;
  logic        ex_done, halt;
  logic [31:0] pc, pc_plus4, instret;
  logic        misalign_trap;
  logic [2:0]  state;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(ResetPc)) u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .branch        (branch),
    .jump          (jump),
    .jalr          (jalr),
    .zero          (zero),
    .lt            (lt),
    .ltu           (ltu),
    .imm           (imm),
    .alu_result    (alu_result),
    .ex_done       (ex_done),
    .halt          (halt),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .instret       (instret),
    .misalign_trap (misalign_trap),
    .state         (state)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;
  bit          trapped;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_ctrl();
    branch     = 1'($urandom_range(0, 1));
    jump       = 1'($urandom_range(0, 1));
    jalr       = 1'($urandom_range(0, 1));
    zero       = 1'($urandom_range(0, 1));
    lt         = 1'($urandom_range(0, 1));
    ltu        = 1'($urandom_range(0, 1));
    imm        = $urandom();
    alu_result = $urandom();
  endtask

  // Architectural next PC from the branch operands rather than raw flags.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [2:0] f3,
                                           input bit br, input bit jmp, input bit jr,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] imm_v, input logic [31:0] alu_v);
    bit t;
    if (jmp && jr) return alu_v & 32'hFFFF_FFFE;
    t = jmp;
    if (!jmp && br) begin
      case (f3)
        3'd0:    t = (a == b);
        3'd1:    t = (a != b);
        3'd4:    t = ($signed(a) < $signed(b));
        3'd5:    t = ($signed(a) >= $signed(b));
        3'd6:    t = (a < b);
        3'd7:    t = (a >= b);
        default: t = 1'b0;
      endcase
    end
    return t ? cur + imm_v : cur + 32'd4;
  endfunction

  task automatic reset_dut();
    rst_n      = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    ex_done    = 1'b0;
    halt       = 1'b0;
    junk_ctrl();
    tick();
    tick();
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_pc", pc, ResetPc);
    check_eq("rst_pc_plus4", pc_plus4, ResetPc + 32'd4);
    check_eq("rst_instr", instr, 32'h0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_instret", instret, 32'h0);
    check_eq("rst_trap", 32'(misalign_trap), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_req_low", 32'(imem_req), 32'd0);
    tick();
    m_pc      = ResetPc;
    m_instret = 32'h0;
  endtask

  task automatic do_instr(input int rdy_dly, input int exec_dly, input logic [2:0] f3,
                          input bit br, input bit jmp, input bit jr,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm_v, input logic [31:0] alu_v,
                          input bit halt_v, input int halt_cyc, output bit trap_o);
    logic [31:0] word;
    logic [31:0] exp_pc;
    trap_o = 1'b0;
    check_eq("fetch_state", 32'(state), 32'd1);
    check_eq("fetch_req", 32'(imem_req), 32'd1);
    check_eq("fetch_addr", imem_addr, m_pc);
    for (int k = 0; k < rdy_dly; k++) begin
      imem_ready = 1'b0;
      ex_done    = 1'($urandom_range(0, 1));
      halt       = 1'($urandom_range(0, 1));
      tick();
      check_eq("stall_req", 32'(imem_req), 32'd1);
      check_eq("stall_addr", imem_addr, m_pc);
    end
    word        = $urandom();
    word[14:12] = f3;
    imem_ready  = 1'b1;
    imem_rdata  = word;
    ex_done     = 1'b0;
    tick();
    check_eq("exec_state", 32'(state), 32'd2);
    check_eq("instr_latched", instr, word);
    check_eq("instr_valid_pulse", 32'(instr_valid), 32'd1);
    imem_rdata = $urandom();
    for (int k = 0; k < exec_dly; k++) begin
      imem_ready = 1'($urandom_range(0, 1));
      halt       = 1'($urandom_range(0, 1));
      ex_done    = 1'b0;
      junk_ctrl();
      tick();
      check_eq("exec_wait_state", 32'(state), 32'd2);
      check_eq("instr_valid_low", 32'(instr_valid), 32'd0);
      check_eq("instr_stable", instr, word);
    end
    imem_ready = 1'b0;
    ex_done    = 1'b1;
    branch     = br;
    jump       = jmp;
    jalr       = jr;
    zero       = (a == b);
    lt         = ($signed(a) < $signed(b));
    ltu        = (a < b);
    imm        = imm_v;
    alu_result = alu_v;
    halt       = 1'($urandom_range(0, 1));
    exp_pc     = ref_next(m_pc, f3, br, jmp, jr, a, b, imm_v, alu_v);
    tick();
    ex_done = 1'b0;
    junk_ctrl();
    check_eq("pc_hold_exec", pc, m_pc);
    if (exp_pc[1:0] != 2'b00) begin
      trap_o = 1'b1;
      check_eq("trap_state", 32'(state), 32'd4);
      check_eq("trap_flag", 32'(misalign_trap), 32'd1);
      check_eq("trap_req", 32'(imem_req), 32'd0);
      for (int k = 0; k < 12; k++) begin
        imem_ready = 1'($urandom_range(0, 1));
        ex_done    = 1'($urandom_range(0, 1));
        halt       = 1'($urandom_range(0, 1));
        tick();
        check_eq("trap_pc_frozen", pc, m_pc);
        check_eq("trap_stays", 32'(state), 32'd4);
        check_eq("trap_req_low", 32'(imem_req), 32'd0);
        check_eq("trap_instret", instret, m_instret);
      end
      return;
    end
    check_eq("update_state", 32'(state), 32'd3);
    halt = halt_v;
    tick();
    m_pc      = exp_pc;
    m_instret = m_instret + 32'd1;
    check_eq("pc_next", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("instret", instret, m_instret);
    if (halt_v) begin
      check_eq("halt_idle", 32'(state), 32'd0);
      check_eq("halt_req", 32'(imem_req), 32'd0);
      for (int k = 0; k < halt_cyc; k++) begin
        tick();
        check_eq("idle_hold", 32'(state), 32'd0);
        check_eq("idle_req", 32'(imem_req), 32'd0);
        check_eq("idle_pc", pc, m_pc);
      end
      halt = 1'b0;
      tick();
    end else begin
      check_eq("refetch_state", 32'(state), 32'd1);
    end
    halt = 1'b0;
  endtask

  task automatic nop(input bit halt_v);
    do_instr(0, 1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, halt_v, 3, trapped);
  endtask

  task automatic jump_to(input logic [31:0] dest);
    do_instr(0, 0, 3'd0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, dest, 1'b0, 0, trapped);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst_n = 1'b0;
    reset_dut();
    check_eq("first_fetch_addr", imem_addr, ResetPc);

    // Straight-line NOPs, ex_done on the second EXEC cycle.
    for (int i = 0; i < 3; i++) nop(1'b0);
    check_eq("three_retired", instret, 32'd3);
    check_eq("pc_after_three", pc, ResetPc + 32'd12);

    // Backward bne taken, then not taken.
    jump_to(32'h0000_0101);
    do_instr(1, 0, 3'd1, 1'b1, 1'b0, 1'b0, 32'd1, 32'd2, 32'hFFFF_FFF0, 32'd0, 1'b0, 0, trapped);
    check_eq("bne_taken_pc", pc, 32'h0000_00F0);
    jump_to(32'h0000_0100);
    do_instr(0, 2, 3'd1, 1'b1, 1'b0, 1'b0, 32'd7, 32'd7, 32'hFFFF_FFF0, 32'd0, 1'b0, 0, trapped);
    check_eq("bne_not_taken_pc", pc, 32'h0000_0104);

    // jalr clears bit 0; jump outranks a failing branch.
    jump_to(32'h0000_0200);
    jump_to(32'h0000_0305);
    check_eq("jalr_pc", pc, 32'h0000_0304);
    jump_to(32'h0000_0200);
    do_instr(0, 0, 3'd0, 1'b1, 1'b1, 1'b0, 32'd1, 32'd2, 32'h0000_0040, 32'd0, 1'b0, 0, trapped);
    check_eq("jump_over_branch_pc", pc, 32'h0000_0240);

    // PC wrap at 2^32, then halt in UPDATE and resume at 0.
    jump_to(32'hFFFF_FFFD);
    check_eq("top_pc", pc, 32'hFFFF_FFFC);
    do_instr(0, 1, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 4, trapped);
    check_eq("wrap_resume_state", 32'(state), 32'd1);
    check_eq("wrap_resume_addr", imem_addr, 32'h0000_0000);

    // Randomized stream with aligned targets.
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? a : $urandom();
      do_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), f3,
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), a, b, $urandom() & 32'hFFFF_FFFC,
               $urandom() & 32'hFFFF_FFFD, ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 3)), trapped);
      check_eq("rand_no_trap", 32'(trapped), 32'd0);
    end

    // Misaligned branch target traps until reset.
    jump_to(32'h0000_0010);
    do_instr(0, 0, 3'd0, 1'b1, 1'b0, 1'b0, 32'd5, 32'd5, 32'h0000_0006, 32'd0, 1'b0, 0, trapped);
    check_eq("trap_taken", 32'(trapped), 32'd1);
    check_eq("trap_pc", pc, 32'h0000_0010);
    reset_dut();

    // Five-cycle fetch stall, then reset in the middle of a stalled fetch.
    jump_to(32'h0000_0080);
    do_instr(5, 0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, trapped);
    check_eq("after_stall_pc", pc, 32'h0000_0084);
    imem_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check_eq("prerst_req", 32'(imem_req), 32'd1);
      check_eq("prerst_addr", imem_addr, 32'h0000_0084);
    end
    imem_ready = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_eq("midfetch_rst_req", 32'(imem_req), 32'd0);
    check_eq("midfetch_rst_pc", pc, ResetPc);
    check_eq("midfetch_rst_state", 32'(state), 32'd0);
    reset_dut();
    nop(1'b0);
    check_eq("final_pc", pc, ResetPc + 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
